s3g_link: RTL and testbench
===========================

// Module: s3g_link
// PURPOSE
//  S3G serial packet engine between a byte UART and the command executor.
//  RX: parses framed packets 0xD5, LEN, PAYLOAD[LEN], CRC8 from a byte-strobe stream.
//  TX: frames a payload supplied by the executor into the same format, byte-paced by UART tx_done.
//  CRC8: Maxim/iButton (reflected poly 0x8C, init 0x00) over payload bytes only.
// PARAMETERS
//  MAX_LEN  32  payload buffer depth in bytes (RX and TX)
// PORTS
//  clk             in   1          single clock, all logic on rising edge
//  rst             in   1          synchronous reset, active-low (rst==0 resets)
//  rx_data         in   8          received byte, valid when rx_done=1
//  rx_done         in   1          1-cycle strobe: new byte on rx_data
//  rx_packet_valid out  1          1-cycle pulse: good packet received
//  rx_crc_error    out  1          1-cycle pulse: CRC mismatch, packet dropped
//  rx_len_error    out  1          1-cycle pulse: LEN > MAX_LEN, packet dropped
//  rx_len          out  8          payload length of last accepted packet
//  rx_payload      out  8*MAX_LEN  payload; byte i at [8*i+7:8*i]
//  rx_busy         out  1          parser outside IDLE
//  packet_wr       in   1          1-cycle strobe: send tx_payload_len bytes of tx_payload
//  tx_payload_len  in   8          payload length to send
//  tx_payload      in   8*MAX_LEN  payload, byte i at [8*i+7:8*i], sampled on packet_wr
//  tx_data         out  8          byte to UART, valid when tx_wr=1
//  tx_wr           out  1          1-cycle strobe to UART
//  tx_done         in   1          1-cycle strobe: UART finished current byte
//  tx_busy         out  1          frame in progress
// BEHAVIOUR
//  Reset (rst==0 at edge): all outputs 0, rx_payload 0, both FSMs IDLE, CRC regs 0.
//  RX FSM, advances only on cycles with rx_done=1:
//   IDLE: byte==0xD5 -> LEN (crc<=0); any other byte ignored.
//   LEN: store rx_len; LEN>MAX_LEN -> rx_len_error pulse, IDLE; LEN==0 -> CRC; else PAYLOAD, idx<=0.
//   PAYLOAD: rx_payload[idx]<=byte, crc<=crc8(crc,byte), idx++; idx==LEN-1 -> CRC.
//   CRC: byte==crc -> rx_packet_valid pulse; else rx_crc_error pulse; -> IDLE.
//   Pulses assert the cycle after the edge that sampled the final byte, last exactly 1 cycle.
//   0xD5 inside LEN/PAYLOAD/CRC is data, no resync. rx_payload written in place;
//   consistent from rx_packet_valid until next 0xD5 accepted in IDLE.
//  TX FSM:
//   IDLE: packet_wr=1 -> latch len=min(tx_payload_len,MAX_LEN) and payload, crc<=0,
//    tx_busy<=1, emit 0xD5 with tx_wr next cycle. packet_wr while tx_busy: ignored.
//   Byte order: 0xD5, len, payload[0..len-1], crc8(payload); len==0 sends D5 00 00.
//   Each byte: tx_data set and tx_wr=1 for one cycle, then WAIT for tx_done; next byte's
//    tx_wr exactly 1 cycle after tx_done cycle. tx_data holds until the next byte is loaded.
//   After tx_done of CRC byte: tx_busy<=0, IDLE. tx_done in IDLE or same cycle as tx_wr: ignored.
//  CRC step per byte: c^=b; 8x: c = c[0] ? (c>>1)^8'h8C : c>>1 (combinational, 1 byte/cycle).
//  RX and TX fully independent; may operate simultaneously.
//  Reset mid-packet on either side: aborts, no pulse, no further tx_wr.
// TESTING
//  rx 0x0D,D5,03,01,02,03,D8 (rx_done, 10-cycle spacing) -> 0x0D ignored; rx_packet_valid, rx_len=3, payload 01 02 03.
//  same with CRC 0xCC -> rx_crc_error pulse only, rx_packet_valid stays 0, parser back to IDLE.
//  rx D5,40 (MAX_LEN=32) -> rx_len_error; then D5,00,00 -> rx_packet_valid, rx_len=0.
//  packet_wr, len=3, payload 01 02 03, tx_done 10 cycles after each tx_wr -> tx_data D5,03,01,02,03,D8; tx_busy low after 6th tx_done.
//  packet_wr during busy, tx_done without pending byte -> no effect; len=0 -> D5 00 00.
//  rst=0 mid-RX-payload and mid-TX-frame -> all outputs 0, next full frame works normally.

Source files
------------

// File: rtl/s3g_link.sv
// S3G serial packet engine: framed RX parser and TX framer (0xD5, LEN, PAYLOAD, CRC8).
// Both directions share the Maxim CRC8 step but run fully independently.
module s3g_link #(
  parameter int MAX_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  output logic                   rx_packet_valid,
  output logic                   rx_crc_error,
  output logic                   rx_len_error,
  output logic [7:0]             rx_len,
  output logic [8*MAX_LEN-1:0]   rx_payload,
  output logic                   rx_busy,
  input  logic                   packet_wr,
  input  logic [7:0]             tx_payload_len,
  input  logic [8*MAX_LEN-1:0]   tx_payload,
  output logic [7:0]             tx_data,
  output logic                   tx_wr,
  input  logic                   tx_done,
  output logic                   tx_busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] SOF   = 8'hD5;
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);

  function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    return c;
  endfunction

  // ---------------- RX parser ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_LEN, RX_PAY, RX_CRC} rx_state_t;
  rx_state_t       rx_state, rx_next;
  logic [IW-1:0]   rx_idx;
  logic [7:0]      rx_crc;

  always_ff @(posedge clk) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (rx_done) begin
      case (rx_state)
        RX_IDLE: if (rx_data == SOF) rx_next = RX_LEN;
        RX_LEN: begin
          if (rx_data > MAX_L)       rx_next = RX_IDLE;
          else if (rx_data == 8'd0)  rx_next = RX_CRC;
          else                       rx_next = RX_PAY;
        end
        RX_PAY:  if (8'(rx_idx) == rx_len - 8'd1) rx_next = RX_CRC;
        RX_CRC:  rx_next = RX_IDLE;
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  assign rx_busy = (rx_state != RX_IDLE);

  // Payload is written in place; it stays stable from the valid pulse until the next frame starts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_packet_valid <= 1'b0;
      rx_crc_error    <= 1'b0;
      rx_len_error    <= 1'b0;
      rx_len          <= 8'd0;
      rx_payload      <= '0;
      rx_idx          <= '0;
      rx_crc          <= 8'd0;
    end else begin
      rx_packet_valid <= 1'b0;
      rx_crc_error    <= 1'b0;
      rx_len_error    <= 1'b0;
      if (rx_done) begin
        case (rx_state)
          RX_IDLE: if (rx_data == SOF) rx_crc <= 8'd0;
          RX_LEN: begin
            rx_len <= rx_data;
            rx_idx <= '0;
            if (rx_data > MAX_L) rx_len_error <= 1'b1;
          end
          RX_PAY: begin
            rx_payload[8*rx_idx +: 8] <= rx_data;
            rx_crc <= crc8_step(rx_crc, rx_data);
            rx_idx <= rx_idx + 1'b1;
          end
          RX_CRC: begin
            if (rx_data == rx_crc) rx_packet_valid <= 1'b1;
            else                   rx_crc_error    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- TX framer ----------------
  // State names the byte currently handed to the UART and awaiting tx_done.
  typedef enum logic [2:0] {TX_IDLE, TX_SOF, TX_LEN, TX_PAY, TX_CRC} tx_state_t;
  tx_state_t          tx_state, tx_next;
  logic [IW:0]        tx_idx;
  logic [7:0]         tx_len;
  logic [7:0]         tx_crc;
  logic [8*MAX_LEN-1:0] tx_buf;
  logic               accept;
  logic               tx_last;
  logic [7:0]         tx_byte;

  assign accept  = tx_done && !tx_wr;
  assign tx_last = (8'(tx_idx) == tx_len);
  assign tx_byte = tx_buf[8*tx_idx +: 8];

  always_ff @(posedge clk) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (packet_wr) tx_next = TX_SOF;
      TX_SOF:  if (accept) tx_next = TX_LEN;
      TX_LEN:  if (accept) tx_next = (tx_len == 8'd0) ? TX_CRC : TX_PAY;
      TX_PAY:  if (accept && tx_last) tx_next = TX_CRC;
      TX_CRC:  if (accept) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_data <= 8'd0;
      tx_wr   <= 1'b0;
      tx_busy <= 1'b0;
      tx_len  <= 8'd0;
      tx_crc  <= 8'd0;
      tx_idx  <= '0;
      tx_buf  <= '0;
    end else begin
      tx_wr <= 1'b0;
      case (tx_state)
        TX_IDLE: if (packet_wr) begin
          tx_len  <= (tx_payload_len > MAX_L) ? MAX_L : tx_payload_len;
          tx_buf  <= tx_payload;
          tx_crc  <= 8'd0;
          tx_idx  <= '0;
          tx_busy <= 1'b1;
          tx_data <= SOF;
          tx_wr   <= 1'b1;
        end
        TX_SOF: if (accept) begin
          tx_data <= tx_len;
          tx_wr   <= 1'b1;
        end
        TX_LEN, TX_PAY: if (accept) begin
          tx_wr <= 1'b1;
          if (tx_last) tx_data <= tx_crc;
          else begin
            tx_data <= tx_byte;
            tx_crc  <= crc8_step(tx_crc, tx_byte);
            tx_idx  <= tx_idx + 1'b1;
          end
        end
        TX_CRC: if (accept) tx_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s3g_link.sv
// Directed bench for s3g_link: RX framing/CRC/length errors, TX framing and pacing, reset abort.
module tb_s3g_link;
  localparam int MAX_LEN = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic                 rx_packet_valid, rx_crc_error, rx_len_error, rx_busy;
  logic [7:0]           rx_len;
  logic [8*MAX_LEN-1:0] rx_payload;
  logic                 packet_wr;
  logic [7:0]           tx_payload_len;
  logic [8*MAX_LEN-1:0] tx_payload;
  logic [7:0]           tx_data;
  logic                 tx_wr, tx_done, tx_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0, n_crc = 0, n_lenerr = 0, n_txwr = 0;
  int base_v, base_c, base_l, base_w;
  logic [7:0] exp_q[$];

  s3g_link #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_done(rx_done),
    .rx_packet_valid(rx_packet_valid), .rx_crc_error(rx_crc_error),
    .rx_len_error(rx_len_error), .rx_len(rx_len), .rx_payload(rx_payload),
    .rx_busy(rx_busy),
    .packet_wr(packet_wr), .tx_payload_len(tx_payload_len), .tx_payload(tx_payload),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done), .tx_busy(tx_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_packet_valid) n_valid++;
    if (rx_crc_error)    n_crc++;
    if (rx_len_error)    n_lenerr++;
    if (tx_wr)           n_txwr++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic rx_byte(input logic [7:0] b);
    repeat (9) step();
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic snap();
    base_v = n_valid; base_c = n_crc; base_l = n_lenerr; base_w = n_txwr;
  endtask

  // Sends one frame; expected bytes are taken from exp_q. With glitch set, a tx_done
  // coincident with the first tx_wr and a second packet_wr mid-frame are injected.
  task automatic tx_frame(input int n, input bit glitch);
    packet_wr = 1'b1;
    step();
    packet_wr = 1'b0;
    check_eq("tx_busy_start", tx_busy, 1);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("tx_wr_on_%0d", i), tx_wr, 1);
      check_eq($sformatf("tx_data_%0d", i), tx_data, exp_q.pop_front());
      if (glitch && i == 0) tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      check_eq($sformatf("tx_wr_pulse_%0d", i), tx_wr, 0);
      if (glitch && i == 1) begin
        packet_wr = 1'b1;
        tx_payload_len = 8'd5;
        tx_payload = {(8*MAX_LEN/32){32'hA5A5_A5A5}};
      end
      step();
      packet_wr = 1'b0;
      repeat (7) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (i < n - 1) check_eq($sformatf("tx_busy_mid_%0d", i), tx_busy, 1);
    end
    check_eq("tx_busy_end", tx_busy, 0);
    check_eq("tx_wr_end", tx_wr, 0);
  endtask

  task automatic rx_good_123();
    snap();
    rx_byte(8'hD5); check_eq("rx_busy_sof", rx_busy, 1);
    rx_byte(8'h03); rx_byte(8'h01); rx_byte(8'hD5 ^ 8'hD7); rx_byte(8'h03);
    rx_byte(8'hD8);
    check_eq("rx_valid_pulse", rx_packet_valid, 1);
    check_eq("rx_len_3", rx_len, 3);
    check_eq("rx_payload_012", rx_payload[23:0], 24'h030201);
    check_eq("rx_busy_done", rx_busy, 0);
    step();
    check_eq("rx_valid_1cyc", rx_packet_valid, 0);
    check_eq("rx_valid_cnt", n_valid - base_v, 1);
    check_eq("rx_err_cnt", (n_crc - base_c) + (n_lenerr - base_l), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; rx_data = 8'd0; rx_done = 1'b0;
    packet_wr = 1'b0; tx_payload_len = 8'd0; tx_payload = '0; tx_done = 1'b0;
    repeat (3) step();
    check_eq("rst_rx_busy", rx_busy, 0);
    check_eq("rst_tx_busy", tx_busy, 0);
    check_eq("rst_tx_wr", tx_wr, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_rx_len", rx_len, 0);
    check_eq("rst_rx_payload", 32'(|rx_payload), 0);
    rst = 1'b1;
    step();

    // noise byte before a good frame
    rx_byte(8'h0D);
    check_eq("rx_ignore_0d", rx_busy, 0);
    rx_good_123();

    // bad CRC
    snap();
    rx_byte(8'hD5); rx_byte(8'h03); rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03);
    rx_byte(8'hCC);
    check_eq("rx_crc_err_pulse", rx_crc_error, 1);
    check_eq("rx_crc_no_valid", rx_packet_valid, 0);
    check_eq("rx_crc_idle", rx_busy, 0);
    step();
    check_eq("rx_crc_err_1cyc", rx_crc_error, 0);
    check_eq("rx_crc_cnt", n_crc - base_c, 1);
    check_eq("rx_crc_valid_cnt", n_valid - base_v, 0);

    // length too large, then empty frame
    snap();
    rx_byte(8'hD5); rx_byte(8'h40);
    check_eq("rx_len_err_pulse", rx_len_error, 1);
    check_eq("rx_len_err_idle", rx_busy, 0);
    rx_byte(8'hD5); rx_byte(8'h00); rx_byte(8'h00);
    check_eq("rx_zero_valid", rx_packet_valid, 1);
    check_eq("rx_zero_len", rx_len, 0);
    check_eq("rx_len_err_cnt", n_lenerr - base_l, 1);

    // TX len=3 with a coincident tx_done and a packet_wr while busy
    tx_payload = '0;
    tx_payload[23:0] = 24'h030201;
    tx_payload_len = 8'd3;
    exp_q = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    tx_frame(6, 1'b1);

    // stray tx_done in IDLE
    snap();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    repeat (5) step();
    check_eq("tx_idle_done_no_wr", n_txwr - base_w, 0);
    check_eq("tx_idle_done_busy", tx_busy, 0);

    // empty and one-byte frames
    tx_payload_len = 8'd0;
    exp_q = '{8'hD5, 8'h00, 8'h00};
    tx_frame(3, 1'b0);
    tx_payload = '0;
    tx_payload[7:0] = 8'h01;
    tx_payload_len = 8'd1;
    exp_q = '{8'hD5, 8'h01, 8'h01, 8'h5E};
    tx_frame(4, 1'b0);

    // reset mid RX payload and mid TX frame
    rx_byte(8'hD5); rx_byte(8'h05); rx_byte(8'hAA); rx_byte(8'hBB);
    tx_payload[23:0] = 24'h030201;
    tx_payload_len = 8'd3;
    packet_wr = 1'b1; step(); packet_wr = 1'b0;
    repeat (3) step();
    snap();
    rst = 1'b0;
    step();
    check_eq("mid_rst_rx_busy", rx_busy, 0);
    check_eq("mid_rst_tx_busy", tx_busy, 0);
    check_eq("mid_rst_tx_wr", tx_wr, 0);
    check_eq("mid_rst_tx_data", tx_data, 0);
    check_eq("mid_rst_rx_len", rx_len, 0);
    check_eq("mid_rst_payload", 32'(|rx_payload), 0);
    rst = 1'b1;
    step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    repeat (5) step();
    check_eq("post_rst_no_wr", n_txwr - base_w, 0);
    check_eq("post_rst_no_pulse", (n_valid - base_v) + (n_crc - base_c) + (n_lenerr - base_l), 0);

    rx_good_123();
    exp_q = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    tx_frame(6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
